// File: rtl/plic_pkg.sv
// Shared PLIC constants, claim-controller state encoding and small helpers.
// PLIC_CLAIM_ERR_EN (optional) enables ignored-complete error tracking in plic_claim_ctrl.
package plic_pkg;

  localparam int PLIC_IRQ_NUM    = 32;
  localparam int PLIC_MAX_OUTSTD = 4;
  localparam int PLIC_HOLDOFF    = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } plic_state_e;

  // Saturating 8-bit increment for event counters.
  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    logic [7:0] res;
    if (val == 8'hFF) begin
      res = val;
    end else begin
      res = val + 8'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/plic_insvc_tbl.sv
// In-service bitmap plus outstanding-claim counter; set/clear are guarded so the
// counter can neither overflow MAX_OUTSTD nor underflow.
module plic_insvc_tbl
  import plic_pkg::*;
#(
  parameter int IRQ_NUM    = PLIC_IRQ_NUM,
  parameter int IRQ_WIDTH  = $clog2(IRQ_NUM),
  parameter int MAX_OUTSTD = PLIC_MAX_OUTSTD,
  parameter int CNT_WIDTH  = $clog2(MAX_OUTSTD + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 set_i,
  input  logic [IRQ_WIDTH-1:0] set_id_i,
  input  logic                 clr_i,
  input  logic [IRQ_WIDTH-1:0] clr_id_i,
  output logic [IRQ_NUM-1:0]   insvc_o,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 full_o
);

  logic [IRQ_NUM-1:0]   insvc_r, insvc_nxt_s;
  logic [CNT_WIDTH-1:0] cnt_r, cnt_nxt_s;
  logic                 do_set_s, do_clr_s;

  assign insvc_o = insvc_r;
  assign cnt_o   = cnt_r;
  assign full_o  = (cnt_r == MAX_OUTSTD[CNT_WIDTH-1:0]);

  // Next bitmap and count from the guarded set/clear requests.
  always_comb begin
    insvc_nxt_s = insvc_r;
    cnt_nxt_s   = cnt_r;
    do_set_s    = set_i && !full_o && !insvc_r[set_id_i];
    do_clr_s    = clr_i && insvc_r[clr_id_i] && (cnt_r != CNT_WIDTH'(0));
    if (do_clr_s) begin
      insvc_nxt_s[clr_id_i] = 1'b0;
    end else begin
      insvc_nxt_s = insvc_nxt_s;
    end
    if (do_set_s) begin
      insvc_nxt_s[set_id_i] = 1'b1;
    end else begin
      insvc_nxt_s = insvc_nxt_s;
    end
    case ({do_set_s, do_clr_s})
      2'b10:   cnt_nxt_s = cnt_r + CNT_WIDTH'(1);
      2'b01:   cnt_nxt_s = cnt_r - CNT_WIDTH'(1);
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Table state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      insvc_r <= {IRQ_NUM{1'b0}};
      cnt_r   <= CNT_WIDTH'(0);
    end else begin
      insvc_r <= insvc_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

endmodule

// File: rtl/plic_claim_ctrl.sv
// Per-target PLIC claim/complete controller with post-strobe holdoff masking.
// Optional macro PLIC_CLAIM_ERR_EN adds err_o / err_cnt_o for ignored completes.
module plic_claim_ctrl
  import plic_pkg::*;
#(
  parameter int IRQ_NUM    = PLIC_IRQ_NUM,
  parameter int IRQ_WIDTH  = $clog2(IRQ_NUM),
  parameter int MAX_OUTSTD = PLIC_MAX_OUTSTD,
  parameter int HOLDOFF    = PLIC_HOLDOFF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 irq_i,
  input  logic [IRQ_WIDTH-1:0] id_i,
  input  logic                 claim_rd_i,
  output logic [IRQ_WIDTH-1:0] claim_data_o,
  output logic                 claim_vld_o,
  input  logic                 comp_wr_i,
  input  logic [IRQ_WIDTH-1:0] comp_id_i,
  output logic                 clam_o,
  output logic                 comp_o,
  output logic [IRQ_WIDTH-1:0] tgt_id_o,
  output logic [IRQ_NUM-1:0]   insvc_o,
  output logic                 eip_o
`ifdef PLIC_CLAIM_ERR_EN
  ,
  output logic                 err_o,
  output logic [7:0]           err_cnt_o
`endif
);

  localparam int HCW = $clog2(HOLDOFF + 1);
  localparam int CW  = $clog2(MAX_OUTSTD + 1);

  plic_state_e          state_r, state_nxt_s;
  logic [HCW-1:0]       hold_r, hold_nxt_s;
  logic [IRQ_NUM-1:0]   insvc_s;
  logic [CW-1:0]        cnt_s;
  logic                 full_s, eip_s, comp_acc_s, claim_acc_s;
  logic                 id_ok_s, comp_id_ok_s;
  logic [IRQ_WIDTH-1:0] claim_data_r, tgt_id_r;
  logic                 claim_vld_r, clam_r, comp_r;

  assign id_ok_s      = (id_i != IRQ_WIDTH'(0)) && ({1'b0, id_i} < IRQ_NUM[IRQ_WIDTH:0]);
  assign comp_id_ok_s = (comp_id_i != IRQ_WIDTH'(0)) && ({1'b0, comp_id_i} < IRQ_NUM[IRQ_WIDTH:0]);
  assign eip_s        = (state_r == IDLE) && irq_i && id_ok_s && !insvc_s[id_i] && !full_s;
  assign comp_acc_s   = comp_wr_i && comp_id_ok_s && insvc_s[comp_id_i];
  // A colliding complete wins; the claim then gets the zero response.
  assign claim_acc_s  = claim_rd_i && eip_s && !comp_acc_s;

  plic_insvc_tbl #(
    .IRQ_NUM   (IRQ_NUM),
    .IRQ_WIDTH (IRQ_WIDTH),
    .MAX_OUTSTD(MAX_OUTSTD),
    .CNT_WIDTH (CW)
  ) u_insvc_tbl (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .set_i   (claim_acc_s),
    .set_id_i(id_i),
    .clr_i   (comp_acc_s),
    .clr_id_i(comp_id_i),
    .insvc_o (insvc_s),
    .cnt_o   (cnt_s),
    .full_o  (full_s)
  );

  // Holdoff FSM next state: any accepted strobe (re)loads the counter.
  always_comb begin
    state_nxt_s = state_r;
    hold_nxt_s  = hold_r;
    if (claim_acc_s || comp_acc_s) begin
      state_nxt_s = HOLD;
      hold_nxt_s  = HOLDOFF[HCW-1:0];
    end else begin
      case (state_r)
        HOLD: begin
          if (hold_r <= HCW'(1)) begin
            state_nxt_s = IDLE;
            hold_nxt_s  = HCW'(0);
          end else begin
            hold_nxt_s = hold_r - HCW'(1);
          end
        end
        default: begin
          state_nxt_s = IDLE;
          hold_nxt_s  = HCW'(0);
        end
      endcase
    end
  end

  // Holdoff FSM state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      hold_r  <= HCW'(0);
    end else begin
      state_r <= state_nxt_s;
      hold_r  <= hold_nxt_s;
    end
  end

  // Registered claim response and single-cycle core strobes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      claim_vld_r  <= 1'b0;
      claim_data_r <= IRQ_WIDTH'(0);
      clam_r       <= 1'b0;
      comp_r       <= 1'b0;
      tgt_id_r     <= IRQ_WIDTH'(0);
    end else begin
      claim_vld_r  <= claim_rd_i;
      claim_data_r <= claim_acc_s ? id_i : IRQ_WIDTH'(0);
      clam_r       <= claim_acc_s;
      comp_r       <= comp_acc_s;
      tgt_id_r     <= comp_acc_s ? comp_id_i : (claim_acc_s ? id_i : IRQ_WIDTH'(0));
    end
  end

  assign claim_vld_o  = claim_vld_r;
  assign claim_data_o = claim_data_r;
  assign clam_o       = clam_r;
  assign comp_o       = comp_r;
  assign tgt_id_o     = tgt_id_r;
  assign insvc_o      = insvc_s;
  assign eip_o        = eip_s;

`ifdef PLIC_CLAIM_ERR_EN
  logic       err_r;
  logic [7:0] err_cnt_r;

  // Sticky flag and saturating count of ignored completes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_r     <= 1'b0;
      err_cnt_r <= 8'd0;
    end else if (comp_wr_i && !comp_acc_s) begin
      err_r     <= 1'b1;
      err_cnt_r <= sat_inc8(err_cnt_r);
    end else begin
      err_r     <= err_r;
      err_cnt_r <= err_cnt_r;
    end
  end

  assign err_o     = err_r;
  assign err_cnt_o = err_cnt_r;
`endif

endmodule

// File: tb/tb_plic_claim_ctrl.sv
// Directed self-checking bench for plic_claim_ctrl (default parameters).
module tb_plic_claim_ctrl;
  import plic_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        irq_i;
  logic [4:0]  id_i;
  logic        claim_rd_i;
  logic [4:0]  claim_data_o;
  logic        claim_vld_o;
  logic        comp_wr_i;
  logic [4:0]  comp_id_i;
  logic        clam_o;
  logic        comp_o;
  logic [4:0]  tgt_id_o;
  logic [31:0] insvc_o;
  logic        eip_o;
`ifdef PLIC_CLAIM_ERR_EN
  logic        err_o;
  logic [7:0]  err_cnt_o;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  plic_claim_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .irq_i       (irq_i),
    .id_i        (id_i),
    .claim_rd_i  (claim_rd_i),
    .claim_data_o(claim_data_o),
    .claim_vld_o (claim_vld_o),
    .comp_wr_i   (comp_wr_i),
    .comp_id_i   (comp_id_i),
    .clam_o      (clam_o),
    .comp_o      (comp_o),
    .tgt_id_o    (tgt_id_o),
    .insvc_o     (insvc_o),
    .eip_o       (eip_o)
`ifdef PLIC_CLAIM_ERR_EN
    ,
    .err_o       (err_o),
    .err_cnt_o   (err_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // One-cycle claim read; returns after the response cycle is visible.
  task automatic claim(input logic [4:0] id);
    irq_i      = 1'b1;
    id_i       = id;
    claim_rd_i = 1'b1;
    cyc();
    claim_rd_i = 1'b0;
  endtask

  task automatic complete(input logic [4:0] id);
    comp_wr_i = 1'b1;
    comp_id_i = id;
    cyc();
    comp_wr_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; irq_i = 1'b0; id_i = 5'd0;
    claim_rd_i = 1'b0; comp_wr_i = 1'b0; comp_id_i = 5'd0;
    cyc(); cyc();
    check("rst_outs", {claim_vld_o, clam_o, comp_o, eip_o, claim_data_o, tgt_id_o}, 32'd0);
    check("rst_insvc", insvc_o, 32'd0);
    rst_i = 1'b0;
    cyc();

    // Basic claim of 7 and holdoff length
    irq_i = 1'b1; id_i = 5'd7; #1;
    check("eip_pre", eip_o, 32'd1);
    claim(5'd7);
    check("clm7_data", claim_data_o, 32'd7);
    check("clm7_vld", claim_vld_o, 32'd1);
    check("clm7_clam", clam_o, 32'd1);
    check("clm7_tgt", tgt_id_o, 32'd7);
    check("clm7_insvc", insvc_o, 32'h0000_0080);
    id_i = 5'd8; #1;
    check("hold_eip1", eip_o, 32'd0);
    cyc();
    check("hold_eip2", eip_o, 32'd0);
    check("clam_pulse", clam_o, 32'd0);
    check("vld_pulse", claim_vld_o, 32'd0);
    cyc();
    check("hold_done", eip_o, 32'd1);
    id_i = 5'd7; #1;
    check("eip_insvc", eip_o, 32'd0);

    // Complete 7, then repeat and zero-ID completes are ignored
    complete(5'd7);
    check("cmp7_comp", comp_o, 32'd1);
    check("cmp7_tgt", tgt_id_o, 32'd7);
    check("cmp7_clam", clam_o, 32'd0);
    check("cmp7_insvc", insvc_o, 32'd0);
    complete(5'd7);
    check("cmp7_again", comp_o, 32'd0);
    complete(5'd0);
    check("cmp0_ign", comp_o, 32'd0);
`ifdef PLIC_CLAIM_ERR_EN
    check("err_flag", err_o, 32'd1);
    check("err_cnt", err_cnt_o, 32'd2);
`endif
    cyc(); cyc();

    // Fill to MAX_OUTSTD, then a further claim is refused
    for (int i = 3; i <= 6; i++) begin
      claim(5'(i));
      check("fill_data", claim_data_o, 32'(i));
      cyc(); cyc();
    end
    check("full_insvc", insvc_o, 32'h0000_0078);
    id_i = 5'd9; #1;
    check("full_eip", eip_o, 32'd0);
    claim(5'd9);
    check("full_data", claim_data_o, 32'd0);
    check("full_vld", claim_vld_o, 32'd1);
    check("full_clam", clam_o, 32'd0);
    complete(5'd4);
    check("cmp4_comp", comp_o, 32'd1);
    check("cmp4_eip1", eip_o, 32'd0);
    cyc();
    check("cmp4_eip2", eip_o, 32'd0);
    cyc();
    check("cmp4_eip3", eip_o, 32'd1);

    // Collision: complete 3 wins over the claim of 9
    claim_rd_i = 1'b1; comp_wr_i = 1'b1; comp_id_i = 5'd3;
    cyc();
    claim_rd_i = 1'b0; comp_wr_i = 1'b0;
    check("col_comp", comp_o, 32'd1);
    check("col_tgt", tgt_id_o, 32'd3);
    check("col_clam", clam_o, 32'd0);
    check("col_data", claim_data_o, 32'd0);
    check("col_vld", claim_vld_o, 32'd1);
    check("col_insvc", insvc_o, 32'h0000_0060);
    cyc(); cyc();

    // Empty claim
    irq_i = 1'b0; claim_rd_i = 1'b1;
    cyc();
    claim_rd_i = 1'b0;
    check("emp_data", claim_data_o, 32'd0);
    check("emp_vld", claim_vld_o, 32'd1);
    check("emp_strb", {clam_o, comp_o}, 32'd0);

    // Reset mid-response and mid-HOLD with insvc[5] set
    claim(5'd9);
    check("pre_rst_clam", clam_o, 32'd1);
    rst_i = 1'b1; irq_i = 1'b0; #1;
    check("mid_rst_outs", {claim_vld_o, clam_o, comp_o, eip_o, claim_data_o, tgt_id_o}, 32'd0);
    check("mid_rst_insvc", insvc_o, 32'd0);
    cyc();
    rst_i = 1'b0;
    cyc();
    check("post_rst_outs", {claim_vld_o, clam_o, comp_o, eip_o}, 32'd0);
`ifdef PLIC_CLAIM_ERR_EN
    check("post_rst_err", {err_o, err_cnt_o}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
